// File: rtl/riscv_core_rob_fill_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// riscv_core_rob_pkg
//   Shared constants for the reorder buffer and the blocks that fill it.
//   Ports: none (package only).
//   - ROB geometry (slot index width, depth)
//   - Requester index map used by the fill arbiter (ALU0, ALU1, MUL/DIV, MEM)
// ----------------------------------------------------------------------------
package riscv_core_rob_pkg;

  // ROB geometry: 32 entries addressed by a 5-bit slot index
  localparam int ROB_SLOT_W = 5;
  localparam int ROB_DEPTH  = 32;

  // Writeback data width and number of execution units competing for fills
  localparam int ROB_DATA_W  = 32;
  localparam int ROB_NUM_REQ = 4;

  // Requester index map for the 2-wide IO2I core
  localparam int REQ_ALU0   = 0;
  localparam int REQ_ALU1   = 1;
  localparam int REQ_MULDIV = 2;
  localparam int REQ_MEM    = 3;

endpackage

// File: rtl/riscv_core_rr_pick2.sv
// ----------------------------------------------------------------------------
// riscv_core_rr_pick2
//   Combinational rotating-priority picker that returns up to two winners.
//   Scanning starts at ptr and wraps modulo NUM_REQ; the first valid bit found
//   is winner A, the second is winner B.
// Ports:
//   val    in  NUM_REQ  request vector
//   ptr    in  PTR_W    highest-priority index (must be < NUM_REQ)
//   a_val  out 1        winner A exists
//   a_idx  out PTR_W    index of winner A
//   b_val  out 1        winner B exists
//   b_idx  out PTR_W    index of winner B
// ----------------------------------------------------------------------------
module riscv_core_rr_pick2
  import riscv_core_rob_pkg::*;
#(
  parameter int NUM_REQ = ROB_NUM_REQ,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] val,
  input  logic [PTR_W-1:0]   ptr,
  output logic               a_val,
  output logic [PTR_W-1:0]   a_idx,
  output logic               b_val,
  output logic [PTR_W-1:0]   b_idx
);

  // One extra bit holds ptr+k before the wrap; ptr+k never exceeds
  // 2*NUM_REQ-2, which always fits, and a single subtraction brings it back
  // into range. This keeps non-power-of-two NUM_REQ correct.
  logic [PTR_W:0] sum;

  always_comb begin
    a_val = 1'b0;
    a_idx = '0;
    b_val = 1'b0;
    b_idx = '0;
    sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      if (val[sum[PTR_W-1:0]]) begin
        if (!a_val) begin
          a_val = 1'b1;
          a_idx = sum[PTR_W-1:0];
        end else if (!b_val) begin
          b_val = 1'b1;
          b_idx = sum[PTR_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/riscv_core_rob_fill_arbiter.sv
// ----------------------------------------------------------------------------
// riscv_core_rob_fill_arbiter
//   Shares the ROB's two fill ports between the execution units. Up to two
//   completing requesters are granted per cycle by rotating priority; their
//   slot/data are registered onto fill port 1 (first winner) and fill port 2
//   (second winner). Also keeps a saturating denied-cycle counter and a sticky
//   duplicate-slot error flag for debug.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   req_val   [NUM_REQ]      requester has a completed result
//   req_slot  [NUM_REQ*SLOT_W] packed ROB slot per requester
//   req_data  [NUM_REQ*DATA_W] packed result per requester
//   req_rdy   [NUM_REQ]      combinational grant per requester
//   rob_fill_val/slot/data_1 registered fill port 1
//   rob_fill_val/slot/data_2 registered fill port 2
//   deny_cnt  [CNT_W]        saturating count of cycles with a denied request
//   err_dup_slot             sticky: both grants carried the same slot
// ----------------------------------------------------------------------------
module riscv_core_rob_fill_arbiter
  import riscv_core_rob_pkg::*;
#(
  parameter int NUM_REQ = ROB_NUM_REQ,
  parameter int SLOT_W  = ROB_SLOT_W,
  parameter int DATA_W  = ROB_DATA_W,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_val,
  input  logic [NUM_REQ*SLOT_W-1:0] req_slot,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_rdy,
  output logic                      rob_fill_val_1,
  output logic                      rob_fill_val_2,
  output logic [SLOT_W-1:0]         rob_fill_slot_1,
  output logic [SLOT_W-1:0]         rob_fill_slot_2,
  output logic [DATA_W-1:0]         rob_fill_data_1,
  output logic [DATA_W-1:0]         rob_fill_data_2,
  output logic [CNT_W-1:0]          deny_cnt,
  output logic                      err_dup_slot
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int POP_W = $clog2(NUM_REQ + 1);

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_next;
  logic              a_val;
  logic              b_val;
  logic [PTR_W-1:0]  a_idx;
  logic [PTR_W-1:0]  b_idx;
  logic              a_gnt;
  logic              b_gnt;
  logic [POP_W-1:0]  req_cnt;
  logic [POP_W-1:0]  gnt_cnt;
  logic              deny_now;
  logic              dup_now;
  logic [SLOT_W-1:0] slot_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  // Unpack the flat request buses so winners can be selected by index
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign slot_arr[i] = req_slot[i*SLOT_W +: SLOT_W];
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  riscv_core_rr_pick2 #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .val   (req_val),
    .ptr   (ptr),
    .a_val (a_val),
    .a_idx (a_idx),
    .b_val (b_val),
    .b_idx (b_idx)
  );

  // Requests are ignored while reset is held so nothing transfers in a
  // reset cycle; every grant-derived signal goes through these two bits.
  assign a_gnt = a_val & ~reset;
  assign b_gnt = b_val & ~reset;

  // Advance to one past the index, wrapping explicitly at NUM_REQ-1
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] idx);
    return (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Grant decode, request/grant population counts, pointer advance and
  // duplicate-slot detection for the current cycle
  always_comb begin
    req_rdy = '0;
    if (a_gnt) req_rdy[a_idx] = 1'b1;
    if (b_gnt) req_rdy[b_idx] = 1'b1;

    req_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_cnt = req_cnt + POP_W'(req_val[i]);
    end
    gnt_cnt  = POP_W'(a_gnt) + POP_W'(b_gnt);
    deny_now = (req_cnt > gnt_cnt);

    // The last winner of the cycle gets lowest priority next time
    ptr_next = ptr;
    if (b_gnt) begin
      ptr_next = wrap_inc(b_idx);
    end else if (a_gnt) begin
      ptr_next = wrap_inc(a_idx);
    end

    dup_now = a_gnt & b_gnt & (slot_arr[a_idx] == slot_arr[b_idx]);
  end

  // Pointer, fill port registers and debug state. Slot/data only load on a
  // grant so the ROB sees stable values between fills.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr             <= '0;
      rob_fill_val_1  <= 1'b0;
      rob_fill_val_2  <= 1'b0;
      rob_fill_slot_1 <= '0;
      rob_fill_slot_2 <= '0;
      rob_fill_data_1 <= '0;
      rob_fill_data_2 <= '0;
      deny_cnt        <= '0;
      err_dup_slot    <= 1'b0;
    end else begin
      ptr            <= ptr_next;
      rob_fill_val_1 <= a_gnt;
      rob_fill_val_2 <= b_gnt;
      if (a_gnt) begin
        rob_fill_slot_1 <= slot_arr[a_idx];
        rob_fill_data_1 <= data_arr[a_idx];
      end
      if (b_gnt) begin
        rob_fill_slot_2 <= slot_arr[b_idx];
        rob_fill_data_2 <= data_arr[b_idx];
      end
      if (deny_now && (deny_cnt != {CNT_W{1'b1}})) begin
        deny_cnt <= deny_cnt + 1'b1;
      end
      if (dup_now) begin
        err_dup_slot <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_core_rob_fill_arbiter.sv
// ----------------------------------------------------------------------------
// tb_riscv_core_rob_fill_arbiter
//   Self-checking bench for the ROB fill arbiter with NUM_REQ=4 and a 4-bit
//   denied-cycle counter so saturation is reachable quickly. A reference model
//   scans requesters by modular arithmetic and tracks the expected fill ports.
// ----------------------------------------------------------------------------
module tb_riscv_core_rob_fill_arbiter;

  localparam int N   = 4;
  localparam int SW  = 5;
  localparam int DW  = 32;
  localparam int CW  = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_val = '0;
  logic [N*SW-1:0] req_slot = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_rdy;
  logic            rob_fill_val_1;
  logic            rob_fill_val_2;
  logic [SW-1:0]   rob_fill_slot_1;
  logic [SW-1:0]   rob_fill_slot_2;
  logic [DW-1:0]   rob_fill_data_1;
  logic [DW-1:0]   rob_fill_data_2;
  logic [CW-1:0]   deny_cnt;
  logic            err_dup_slot;

  riscv_core_rob_fill_arbiter #(
    .NUM_REQ (N),
    .SLOT_W  (SW),
    .DATA_W  (DW),
    .CNT_W   (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_val         (req_val),
    .req_slot        (req_slot),
    .req_data        (req_data),
    .req_rdy         (req_rdy),
    .rob_fill_val_1  (rob_fill_val_1),
    .rob_fill_val_2  (rob_fill_val_2),
    .rob_fill_slot_1 (rob_fill_slot_1),
    .rob_fill_slot_2 (rob_fill_slot_2),
    .rob_fill_data_1 (rob_fill_data_1),
    .rob_fill_data_2 (rob_fill_data_2),
    .deny_cnt        (deny_cnt),
    .err_dup_slot    (err_dup_slot)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Per-requester payload the stimulus presents
  logic [SW-1:0] tslot [N];
  logic [DW-1:0] tdata [N];

  // Reference model state
  int            m_ptr;
  int            ga;
  int            gb;
  logic [N-1:0]  exp_rdy;
  bit            m_fv1, m_fv2;
  logic [SW-1:0] m_s1, m_s2;
  logic [DW-1:0] m_d1, m_d2;
  int            m_cnt;
  bit            m_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Compare one observed value against the model and tally the result
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_cmp++;
    if (observed !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Winners for this cycle: first and second valid requesters found walking
  // from the priority pointer around the ring
  task automatic modelGrant();
    ga = -1;
    gb = -1;
    exp_rdy = '0;
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (req_val[i]) begin
          if (ga < 0) ga = i;
          else if (gb < 0) gb = i;
        end
      end
    end
    if (ga >= 0) exp_rdy[ga] = 1'b1;
    if (gb >= 0) exp_rdy[gb] = 1'b1;
  endtask

  // Expected register contents after the clock edge
  task automatic modelUpdate();
    if (reset) begin
      m_ptr = 0; m_fv1 = 0; m_fv2 = 0;
      m_s1 = '0; m_s2 = '0; m_d1 = '0; m_d2 = '0;
      m_cnt = 0; m_err = 0;
    end else begin
      int granted;
      granted = (ga >= 0 ? 1 : 0) + (gb >= 0 ? 1 : 0);
      if ($countones(req_val) > granted && m_cnt < CNT_MAX) m_cnt++;
      m_fv1 = (ga >= 0);
      m_fv2 = (gb >= 0);
      if (ga >= 0) begin m_s1 = tslot[ga]; m_d1 = tdata[ga]; end
      if (gb >= 0) begin m_s2 = tslot[gb]; m_d2 = tdata[gb]; end
      if (ga >= 0 && gb >= 0 && tslot[ga] == tslot[gb]) m_err = 1;
      if (gb >= 0) m_ptr = (gb + 1) % N;
      else if (ga >= 0) m_ptr = (ga + 1) % N;
    end
  endtask

  // Drive one cycle of requests, check the grant, clock, check the registers
  task automatic applyStimulus(input logic [N-1:0] v);
    req_val = v;
    for (int i = 0; i < N; i++) begin
      req_slot[i*SW +: SW] = tslot[i];
      req_data[i*DW +: DW] = tdata[i];
    end
    #1;
    modelGrant();
    checkOutput("req_rdy", 64'(req_rdy), 64'(exp_rdy));
    @(posedge clk);
    modelUpdate();
    #1;
    checkOutput("fill_val_1",  64'(rob_fill_val_1),  64'(m_fv1));
    checkOutput("fill_val_2",  64'(rob_fill_val_2),  64'(m_fv2));
    checkOutput("fill_slot_1", 64'(rob_fill_slot_1), 64'(m_s1));
    checkOutput("fill_slot_2", 64'(rob_fill_slot_2), 64'(m_s2));
    checkOutput("fill_data_1", 64'(rob_fill_data_1), 64'(m_d1));
    checkOutput("fill_data_2", 64'(rob_fill_data_2), 64'(m_d2));
    checkOutput("deny_cnt",    64'(deny_cnt),        64'(m_cnt));
    checkOutput("err_dup",     64'(err_dup_slot),    64'(m_err));
  endtask

  // Hold reset for a few cycles while still presenting the given requests
  task automatic doReset(input int cycles, input logic [N-1:0] v);
    reset = 1'b1;
    repeat (cycles) applyStimulus(v);
    reset = 1'b0;
  endtask

  // Safety net so the run always ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [N-1:0] pend;

  initial begin
    for (int i = 0; i < N; i++) begin
      tslot[i] = SW'(i + 1);
      tdata[i] = 32'h1000 + DW'(i);
    end
    m_ptr = 0; m_cnt = 0; m_err = 0;

    // Reset state
    doReset(2, '0);

    // Single requester: MUL/DIV with slot 7, data 0xDEAD; pointer moves to 3
    tslot[2] = 5'd7; tdata[2] = 32'hDEAD;
    applyStimulus(4'b0100);
    checkOutput("single_slot", 64'(rob_fill_slot_1), 64'd7);
    checkOutput("single_data", 64'(rob_fill_data_1), 64'hDEAD);
    applyStimulus(4'b0000);

    // All four held for four cycles from ptr=0
    doReset(1, '0);
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < N; i++) begin
        tslot[i] = SW'(4*c + i);
        tdata[i] = 32'hA000 + DW'(16*c + i);
      end
      applyStimulus(4'b1111);
    end
    checkOutput("all4_deny", 64'(deny_cnt), 64'd4);

    // Wrap: drive ptr to 3, then requesters 3 and 0 cross the boundary
    doReset(1, '0);
    applyStimulus(4'b0100);
    tslot[3] = 5'd21; tdata[3] = 32'h3333_0003;
    tslot[0] = 5'd22; tdata[0] = 32'h0000_0A0A;
    applyStimulus(4'b1001);
    checkOutput("wrap_port1", 64'(rob_fill_slot_1), 64'd21);
    checkOutput("wrap_port2", 64'(rob_fill_slot_2), 64'd22);
    // ptr=1: grants go to 1,2; 3 and 0 are denied and hold their payloads
    tslot[1] = 5'd9;  tdata[1] = 32'h1111_0001;
    tslot[2] = 5'd10; tdata[2] = 32'h2222_0002;
    tslot[3] = 5'd11; tdata[3] = 32'hCAFE_0003;
    tslot[0] = 5'd12; tdata[0] = 32'hBEEF_0000;
    applyStimulus(4'b1111);
    applyStimulus(4'b1001);
    checkOutput("held_data_3", 64'(rob_fill_data_1), 64'hCAFE_0003);
    checkOutput("held_data_0", 64'(rob_fill_data_2), 64'hBEEF_0000);

    // Duplicate slot is flagged and sticks until reset
    doReset(1, '0);
    tslot[0] = 5'd12; tslot[1] = 5'd12;
    applyStimulus(4'b0011);
    repeat (3) applyStimulus(4'b0000);
    checkOutput("dup_sticky", 64'(err_dup_slot), 64'd1);
    doReset(1, '0);

    // Saturation: three requesters for 20 cycles, counter pins at 15
    tslot[0] = 5'd1; tslot[1] = 5'd2; tslot[2] = 5'd3;
    repeat (20) applyStimulus(4'b0111);
    checkOutput("deny_sat", 64'(deny_cnt), 64'(CNT_MAX));

    // Reset mid-stream: grant, then reset with requests still asserted
    applyStimulus(4'b0011);
    doReset(1, 4'b0011);
    checkOutput("mid_rst_val1", 64'(rob_fill_val_1), 64'd0);
    applyStimulus(4'b0011);

    // Randomized traffic obeying the hold-until-granted rule
    pend = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 60) begin
          pend[i]  = 1'b1;
          tslot[i] = SW'($urandom_range(0, 31));
          tdata[i] = $urandom;
        end
      end
      reset = ($urandom_range(0, 59) == 0);
      applyStimulus(pend);
      if (ga >= 0) pend[ga] = 1'b0;
      if (gb >= 0) pend[gb] = 1'b0;
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_core_rob_fill_arbiter.md
# riscv_core_rob_fill_arbiter

The ROB fill arbiter shares the reorder buffer's two fill ports between the 2-wide IO2I core's execution units (ALU0, ALU1, MUL/DIV, MEM). Each cycle it selects up to two completing requesters by rotating priority. It registers their slot/data onto fill port 1 and fill port 2, and feeds the writeback data to the ROB data store. It also keeps a saturating count of denied-request cycles and a sticky duplicate-slot error flag for debug.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..8.
- SLOT_W, 5, ROB slot index width; matches the 32-entry ROB.
- DATA_W, 32, writeback data width.
- CNT_W, 16, width of the denied-cycle counter.
- clk  in  1  core clock; one clock domain only.
- reset  in  1  synchronous, active-high reset.
- req_val  in  NUM_REQ  bit i: requester i has a completed result.
- req_slot  in  NUM_REQ*SLOT_W  packed ROB slot per requester; requester i occupies bits [i*SLOT_W +: SLOT_W].
- req_data  in  NUM_REQ*DATA_W  packed result per requester, packed the same way.
- req_rdy  out  NUM_REQ  bit i: requester i is granted this cycle (combinational).
- rob_fill_val_1 / rob_fill_val_2  out  1  registered fill strobes to the ROB.
- rob_fill_slot_1 / rob_fill_slot_2  out  SLOT_W  registered fill slots.
- rob_fill_data_1 / rob_fill_data_2  out  DATA_W  registered fill data.
- deny_cnt  out  CNT_W  saturating count of cycles with at least one valid, ungranted requester.
- err_dup_slot  out  1  sticky; set when both grants in one cycle carry the same slot.

## Operation
- Priority pointer ptr, width clog2(NUM_REQ), selects the highest-priority requester.
- Scan order: ptr, ptr+1, … wrapping mod NUM_REQ.
  - The first valid requester in scan order is grant A and goes to port 1.
  - The second valid requester is grant B and goes to port 2.
  - At most two grants per cycle.
- req_rdy[i] = 1 only for the granted requesters, so a transfer occurs when req_val[i] & req_rdy[i].
- A denied requester must hold val, slot and data stable until it is granted. Requesters must not derive req_val from req_rdy.
- Pointer update at the clock edge:
  - If B is granted: ptr <= (B+1) mod NUM_REQ.
  - Else if only A is granted: ptr <= (A+1) mod NUM_REQ.
  - If there are no grants: ptr is unchanged.
- Output registers:
  - rob_fill_val_1 <= A granted.
  - rob_fill_val_2 <= B granted.
  - Slot and data registers load only when their port is granted and otherwise hold their previous values.
  - When only one requester is granted, it always uses port 1.
- deny_cnt increments when popcount(req_val) > number of grants. It saturates at 2^CNT_W-1 and never wraps.
- err_dup_slot is set when A and B are both granted and req_slot[A] == req_slot[B]. Both fills are still issued. Only reset clears the flag.

## Timing
- Reset values: ptr=0, all rob_fill_* =0, deny_cnt=0, err_dup_slot=0. req_rdy is combinational, so it is 0 whenever req_val is 0.
- Requests are ignored during reset: while reset=1, req_rdy is forced to 0, so no transfer occurs in a reset cycle.
- Latency: a grant in cycle N puts the fill on the ROB ports in cycle N+1. The ROB clears the pending bit at the end of N+1.
- Throughput: 2 fills per cycle sustained. The arbiter has no internal queue, so back-pressure exists only through req_rdy.
- Pointer wrap: with ptr=NUM_REQ-1, the scan wraps to 0. NUM_REQ need not be a power of two; use explicit mod logic.
- Reset asserted mid-stream drops the fills registered for the next cycle, and the counter restarts at 0.

## Structure
- Shared package riscv_core_rob_pkg holds:
  - ROB_SLOT_W=5 and ROB_DEPTH=32.
  - Requester index constants: REQ_ALU0=0, REQ_ALU1=1, REQ_MULDIV=2, REQ_MEM=3.
- One sub-module, riscv_core_rr_pick2: a combinational rotating two-winner picker taking (val vector, ptr) and returning (A valid/index, B valid/index). The top-level module owns ptr, the output registers, deny_cnt and err_dup_slot.

## Test plan
- Single requester: reset, then req_val=0b0100, slot 7, data 0xDEAD → req_rdy=0b0100. Next cycle: fill_val_1=1, slot_1=7, data_1=0xDEAD, fill_val_2=0. ptr becomes 3.
- All four requesting, held 4 cycles, from ptr=0:
  - Grants are {0,1}, {2,3}, {0,1}, {2,3}.
  - Ports carry the lower scan-order index on port 1.
  - deny_cnt counts 4.
- Wrap with hold: ptr=3, req_val=0b1001 → port 1 = req 3, port 2 = req 0, ptr becomes 1. The denied requester keeps its data until granted and is verified to arrive unchanged.
- Duplicate slot: req 0 and req 1 both use slot 12 → both fills are issued with slot 12. err_dup_slot=1 and stays 1 until reset.
- Saturation: CNT_W=4, 3 requesters held for 20 cycles → deny_cnt stops at 15.
- Reset mid-stream: assert reset in the cycle after a grant → fill_val_1/2=0 next cycle, ptr=0, deny_cnt=0, req_rdy=0 during reset.
